// File: rtl/linear_release_queue_if.sv
// Grant / issue / free handshake bundle between the allocator, the queue and the fill stage.
interface linear_release_queue_if #(
    parameter int LBW     = 12,
    parameter int ICFG_BW = 3
) ();
    logic               linear_rdy;
    logic               linear_ack;
    logic [LBW-1:0]     i_linear;
    logic [ICFG_BW-1:0] i_linear_id;
    logic               issue_rdy;
    logic               issue_ack;
    logic [LBW-1:0]     o_issue;
    logic [ICFG_BW-1:0] o_issue_id;
    logic               done_dval;
    logic               free_dval;
    logic [ICFG_BW-1:0] o_free_id;

    modport slave (
        input  linear_rdy, i_linear, i_linear_id, issue_ack, done_dval,
        output linear_ack, issue_rdy, o_issue, o_issue_id, free_dval, o_free_id
    );

    modport master (
        output linear_rdy, i_linear, i_linear_id, issue_ack, done_dval,
        input  linear_ack, issue_rdy, o_issue, o_issue_id, free_dval, o_free_id
    );
endinterface

// File: rtl/linear_release_queue.sv
// In-order grant queue: issues grants downstream and returns frees to the allocator in allocation order.
// Optional LRQ_ERR_CHK_EN adds a sticky o_err flag for done-without-issue and ack-without-ready.
module linear_release_queue #(
    parameter int LBW    = 12,
    parameter int N_ICFG = 7,
    parameter int DEPTH  = 4
) (
    input  logic i_clk,
    input  logic i_rst,
`ifdef LRQ_ERR_CHK_EN
    output logic o_err,
`endif
    linear_release_queue_if.slave bus
);
    localparam int ICFG_BW = $clog2(N_ICFG + 1);
    localparam int PBW     = $clog2(DEPTH) + 1;
    localparam int IBW     = PBW - 1;

    logic [LBW-1:0]     mem_addr [DEPTH];
    logic [ICFG_BW-1:0] mem_id   [DEPTH];

    logic [PBW-1:0] wptr, iptr, rptr;
    logic [PBW-1:0] wptr_next, iptr_next;
    logic           full, push, issue, retire, fwd;

    // Full is judged on pre-retire pointers, so a same-cycle retire never frees room for a push.
    always_comb begin
        full      = (wptr[PBW-1] != rptr[PBW-1]) && (wptr[IBW-1:0] == rptr[IBW-1:0]);
        push      = bus.linear_rdy && !full;
        issue     = bus.issue_rdy && bus.issue_ack;
        retire    = bus.done_dval && (rptr != iptr);
        wptr_next = wptr + PBW'(push);
        iptr_next = iptr + PBW'(issue);
        fwd       = push && (wptr[IBW-1:0] == iptr_next[IBW-1:0]);
    end

    assign bus.linear_ack = push;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_addr[wptr[IBW-1:0]] <= bus.i_linear;
            mem_id[wptr[IBW-1:0]]   <= bus.i_linear_id;
        end
    end

    // The issue head is registered; a grant landing in the slot about to become the head is forwarded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr           <= '0;
            iptr           <= '0;
            rptr           <= '0;
            bus.issue_rdy  <= 1'b0;
            bus.o_issue    <= '0;
            bus.o_issue_id <= '0;
            bus.free_dval  <= 1'b0;
            bus.o_free_id  <= '0;
        end else begin
            wptr          <= wptr_next;
            iptr          <= iptr_next;
            bus.issue_rdy <= (wptr_next != iptr_next);
            if (fwd) begin
                bus.o_issue    <= bus.i_linear;
                bus.o_issue_id <= bus.i_linear_id;
            end else begin
                bus.o_issue    <= mem_addr[iptr_next[IBW-1:0]];
                bus.o_issue_id <= mem_id[iptr_next[IBW-1:0]];
            end
            bus.free_dval <= retire;
            if (retire) begin
                rptr          <= rptr + PBW'(1);
                bus.o_free_id <= mem_id[rptr[IBW-1:0]];
            end
        end
    end

`ifdef LRQ_ERR_CHK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if ((bus.done_dval && (rptr == iptr)) || (bus.issue_ack && !bus.issue_rdy)) begin
            o_err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_linear_release_queue.sv
// Bench for linear_release_queue: queue-level reference model checked every cycle plus directed literal checks.
module tb_linear_release_queue;
    localparam int LBW     = 12;
    localparam int N_ICFG  = 7;
    localparam int DEPTH   = 4;
    localparam int ICFG_BW = $clog2(N_ICFG + 1);

    typedef struct {
        logic [LBW-1:0]     addr;
        logic [ICFG_BW-1:0] id;
    } grant_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
`ifdef LRQ_ERR_CHK_EN
    logic o_err;
`endif

    int checks = 0;
    int errors = 0;

    linear_release_queue_if #(.LBW(LBW), .ICFG_BW(ICFG_BW)) bus ();

    linear_release_queue #(.LBW(LBW), .N_ICFG(N_ICFG), .DEPTH(DEPTH)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
`ifdef LRQ_ERR_CHK_EN
        .o_err (o_err),
`endif
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    grant_t             wq[$];
    logic [ICFG_BW-1:0] iq[$];
    logic               m_issue_rdy = 1'b0;
    logic [LBW-1:0]     m_issue = '0;
    logic [ICFG_BW-1:0] m_issue_id = '0;
    logic               m_free_dval = 1'b0;
    logic [ICFG_BW-1:0] m_free_id = '0;
    logic               m_err = 1'b0;
    bit                 model_valid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grants waiting to issue and issued ids awaiting done, tracked as plain queues.
    initial begin
        forever begin
            @(posedge i_clk);
            if (i_rst) begin
                wq.delete();
                iq.delete();
                m_issue_rdy = 1'b0;
                m_issue     = '0;
                m_issue_id  = '0;
                m_free_dval = 1'b0;
                m_free_id   = '0;
                m_err       = 1'b0;
                model_valid = 1'b1;
            end else begin
                bit     full_m, push_m, iss_m, ret_m;
                grant_t g;
                full_m = (wq.size() + iq.size()) == DEPTH;
                push_m = bus.linear_rdy && !full_m;
                iss_m  = m_issue_rdy && bus.issue_ack;
                ret_m  = bus.done_dval && (iq.size() > 0);
                if ((bus.done_dval && iq.size() == 0) || (bus.issue_ack && !m_issue_rdy))
                    m_err = 1'b1;
                m_free_dval = ret_m;
                if (ret_m) m_free_id = iq.pop_front();
                if (iss_m) begin
                    g = wq.pop_front();
                    iq.push_back(g.id);
                end
                if (push_m) begin
                    g.addr = bus.i_linear;
                    g.id   = bus.i_linear_id;
                    wq.push_back(g);
                end
                m_issue_rdy = wq.size() > 0;
                if (m_issue_rdy) begin
                    m_issue    = wq[0].addr;
                    m_issue_id = wq[0].id;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (model_valid) begin
                checkOutput("linear_ack", 32'(bus.linear_ack),
                            32'(bus.linear_rdy && ((wq.size() + iq.size()) < DEPTH)));
                checkOutput("issue_rdy", 32'(bus.issue_rdy), 32'(m_issue_rdy));
                if (m_issue_rdy) begin
                    checkOutput("o_issue", 32'(bus.o_issue), 32'(m_issue));
                    checkOutput("o_issue_id", 32'(bus.o_issue_id), 32'(m_issue_id));
                end
                checkOutput("free_dval", 32'(bus.free_dval), 32'(m_free_dval));
                if (m_free_dval) checkOutput("o_free_id", 32'(bus.o_free_id), 32'(m_free_id));
`ifdef LRQ_ERR_CHK_EN
                checkOutput("o_err", 32'(o_err), 32'(m_err));
`endif
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic rdy, input logic [LBW-1:0] addr,
                                 input logic [ICFG_BW-1:0] id, input logic iack, input logic done);
        @(posedge i_clk);
        #1;
        i_rst           = rst;
        bus.linear_rdy  = rdy;
        bus.i_linear    = addr;
        bus.i_linear_id = id;
        bus.issue_ack   = iack;
        bus.done_dval   = done;
        #3;
    endtask

    // Drain without protocol violations by steering ack/done from the model's view of the queue.
    task automatic drain(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            i_rst           = 1'b0;
            bus.linear_rdy  = 1'b0;
            bus.i_linear    = '0;
            bus.i_linear_id = '0;
            bus.issue_ack   = m_issue_rdy;
            bus.done_dval   = iq.size() > 0;
            #3;
        end
    endtask

    initial begin
        int ack_count;
        bus.linear_rdy  = 1'b0;
        bus.i_linear    = '0;
        bus.i_linear_id = '0;
        bus.issue_ack   = 1'b0;
        bus.done_dval   = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst_issue_rdy", 32'(bus.issue_rdy), 0);
        checkOutput("rst_free_dval", 32'(bus.free_dval), 0);
        checkOutput("rst_o_issue", 32'(bus.o_issue), 0);
        checkOutput("rst_o_issue_id", 32'(bus.o_issue_id), 0);
        checkOutput("rst_o_free_id", 32'(bus.o_free_id), 0);

        applyStimulus(0, 1, 12'h010, 3'd1, 0, 0);
        checkOutput("t1_ack", 32'(bus.linear_ack), 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_issue_rdy", 32'(bus.issue_rdy), 1);
        checkOutput("t1_o_issue", 32'(bus.o_issue), 32'h010);
        checkOutput("t1_o_issue_id", 32'(bus.o_issue_id), 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t1_issue_rdy_after", 32'(bus.issue_rdy), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_free_dval", 32'(bus.free_dval), 1);
        checkOutput("t1_free_id", 32'(bus.o_free_id), 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_free_pulse", 32'(bus.free_dval), 0);

        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, LBW'(12'h100 + k), ICFG_BW'(k + 1), 0, 0);
            checkOutput("t2_fill_ack", 32'(bus.linear_ack), (k < 4) ? 1 : 0);
        end
        applyStimulus(0, 1, 12'h104, 3'd5, 1, 0);
        checkOutput("t2_full_issue_ack", 32'(bus.linear_ack), 0);
        applyStimulus(0, 1, 12'h104, 3'd5, 0, 1);
        checkOutput("t2_full_retire_ack", 32'(bus.linear_ack), 0);
        applyStimulus(0, 1, 12'h104, 3'd5, 0, 0);
        checkOutput("t2_after_retire_ack", 32'(bus.linear_ack), 1);
        drain(10);

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, LBW'(12'h300 + i), ICFG_BW'(i + 1), 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t3_free1", 32'(bus.o_free_id), 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t3_free2", 32'(bus.o_free_id), 2);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t3_free3", 32'(bus.o_free_id), 3);
        checkOutput("t3_free3_dval", 32'(bus.free_dval), 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t3_no_extra_free", 32'(bus.free_dval), 0);

        ack_count = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, LBW'(12'h200 + i), ICFG_BW'((i % 7) + 1), i >= 1, i >= 2);
            if (bus.linear_ack) ack_count++;
        end
        checkOutput("t4_throughput", 32'(ack_count), 20);
        drain(6);

`ifdef LRQ_ERR_CHK_EN
        checkOutput("t5_err_clear", 32'(o_err), 0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5_no_free", 32'(bus.free_dval), 0);
`ifdef LRQ_ERR_CHK_EN
        checkOutput("t5_err_set", 32'(o_err), 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5_err_sticky", 32'(o_err), 1);
`endif

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, LBW'(12'h400 + i), ICFG_BW'(i + 1), 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 12'h500, 3'd2, 0, 0);
        checkOutput("t6_issue_rdy", 32'(bus.issue_rdy), 0);
        checkOutput("t6_free_dval", 32'(bus.free_dval), 0);
        checkOutput("t6_ack_follows", 32'(bus.linear_ack), 1);
`ifdef LRQ_ERR_CHK_EN
        checkOutput("t6_err_reset", 32'(o_err), 0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6_ack_low", 32'(bus.linear_ack), 0);
        checkOutput("t6_new_issue_rdy", 32'(bus.issue_rdy), 1);
        checkOutput("t6_new_o_issue", 32'(bus.o_issue), 32'h500);
        drain(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
